// File: rtl/axi_lite_if.sv
// AXI-lite bundle shared by the arbiter side (master) and the SRAM responder (slave).
interface axi_lite_if #(
    parameter int ADDR_W = 32
) ();
    logic [ADDR_W-1:0] araddr;
    logic              arvalid;
    logic              arready;
    logic [31:0]       rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;
    logic [ADDR_W-1:0] awaddr;
    logic              awvalid;
    logic              awready;
    logic [31:0]       wdata;
    logic [3:0]        wstrb;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;

    modport slave (
        input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
        output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
    );

    modport master (
        output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
        input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
    );
endinterface

// File: rtl/ysyx_24110015_axi_sram.sv
// AXI-lite word-addressed SRAM responder with programmable read/write latency,
// serving one transaction at a time and answering DECERR outside its window.
module ysyx_24110015_axi_sram #(
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 32,
    parameter logic [ADDR_W-1:0] MEM_BASE  = 32'h8000_0000,
    parameter int                MEM_WORDS = 4096,
    parameter int                RD_LAT    = 1,
    parameter int                WR_LAT    = 1
) (
    input  logic     clk,
    input  logic     rst,
    axi_lite_if.slave axi
);
    localparam int                IDX_W    = $clog2(MEM_WORDS);
    localparam logic [ADDR_W-1:0] MEM_SPAN = ADDR_W'(MEM_WORDS * 4);
    localparam logic [3:0]        RD_LAT_C = 4'(RD_LAT);
    localparam logic [3:0]        WR_LAT_C = 4'(WR_LAT);

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        RD_RESP,
        WR_COLLECT,
        WR_WAIT,
        WR_RESP
    } state_t;

    state_t              state, state_nx;
    logic [3:0]          cnt, cnt_nx;
    logic                aw_done, w_done, aw_done_nx, w_done_nx;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [3:0]          wstrb_q;
    logic [DATA_W-1:0]   rdata_q;
    logic [1:0]          rresp_q, bresp_q;
    logic [DATA_W-1:0]   mem [MEM_WORDS];

    logic                ar_hs, aw_hs, w_hs, rd_load, wr_commit;
    logic [ADDR_W-1:0]   rd_addr, rd_off, wr_addr, wr_off;
    logic [DATA_W-1:0]   wr_data;
    logic [3:0]          wr_strb;
    logic [IDX_W-1:0]    rd_idx, wr_idx;
    logic                rd_in, wr_in;

    assign axi.arready = !rst && (state == IDLE);
    assign axi.awready = !rst && (((state == IDLE) && !axi.arvalid) ||
                                  ((state == WR_COLLECT) && !aw_done));
    assign axi.wready  = !rst && (((state == IDLE) && !axi.arvalid) ||
                                  ((state == WR_COLLECT) && !w_done));
    assign axi.rvalid  = (state == RD_RESP);
    assign axi.bvalid  = (state == WR_RESP);
    assign axi.rdata   = rdata_q;
    assign axi.rresp   = rresp_q;
    assign axi.bresp   = bresp_q;

    assign ar_hs = axi.arvalid && axi.arready;
    assign aw_hs = axi.awvalid && axi.awready;
    assign w_hs  = axi.wvalid && axi.wready;

    // With zero latency the response is registered on the handshake edge itself,
    // so the decode must look at the live bus rather than the captured copy.
    assign rd_addr = (state == IDLE) ? axi.araddr : addr_q;
    assign wr_addr = aw_hs ? axi.awaddr : addr_q;
    assign wr_data = w_hs ? axi.wdata : wdata_q;
    assign wr_strb = w_hs ? axi.wstrb : wstrb_q;

    assign rd_off = rd_addr - MEM_BASE;
    assign wr_off = wr_addr - MEM_BASE;
    assign rd_in  = rd_off < MEM_SPAN;
    assign wr_in  = wr_off < MEM_SPAN;
    assign rd_idx = rd_off[IDX_W+1:2];
    assign wr_idx = wr_off[IDX_W+1:2];

    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        rd_load    = 1'b0;
        wr_commit  = 1'b0;
        aw_done_nx = aw_done || aw_hs;
        w_done_nx  = w_done || w_hs;
        case (state)
            IDLE, WR_COLLECT: begin
                if (ar_hs) begin
                    cnt_nx = RD_LAT_C;
                    if (RD_LAT == 0) begin
                        state_nx = RD_RESP;
                        rd_load  = 1'b1;
                    end else begin
                        state_nx = RD_WAIT;
                    end
                end else if (aw_done_nx && w_done_nx) begin
                    cnt_nx = WR_LAT_C;
                    if (WR_LAT == 0) begin
                        state_nx  = WR_RESP;
                        wr_commit = 1'b1;
                    end else begin
                        state_nx = WR_WAIT;
                    end
                end else if (aw_done_nx || w_done_nx) begin
                    state_nx = WR_COLLECT;
                end
            end
            RD_WAIT: begin
                if (cnt <= 4'd1) begin
                    cnt_nx   = 4'd0;
                    state_nx = RD_RESP;
                    rd_load  = 1'b1;
                end else begin
                    cnt_nx = cnt - 4'd1;
                end
            end
            RD_RESP: begin
                if (axi.rready) state_nx = IDLE;
            end
            WR_WAIT: begin
                if (cnt <= 4'd1) begin
                    cnt_nx    = 4'd0;
                    state_nx  = WR_RESP;
                    wr_commit = 1'b1;
                end else begin
                    cnt_nx = cnt - 4'd1;
                end
            end
            WR_RESP: begin
                if (axi.bready) begin
                    state_nx   = IDLE;
                    aw_done_nx = 1'b0;
                    w_done_nx  = 1'b0;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= 4'd0;
            rdata_q <= '0;
            rresp_q <= 2'b00;
            bresp_q <= 2'b00;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            aw_done <= aw_done_nx;
            w_done  <= w_done_nx;
            if (ar_hs) addr_q <= axi.araddr;
            else if (aw_hs) addr_q <= axi.awaddr;
            if (w_hs) begin
                wdata_q <= axi.wdata;
                wstrb_q <= axi.wstrb;
            end
            if (rd_load) begin
                rdata_q <= rd_in ? mem[rd_idx] : '0;
                rresp_q <= rd_in ? 2'b00 : 2'b11;
            end
            if (wr_commit) bresp_q <= wr_in ? 2'b00 : 2'b11;
        end
    end

    // Storage is deliberately not reset; a reset on the commit edge suppresses the write.
    always_ff @(posedge clk) begin
        if (!rst && wr_commit && wr_in) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_strb[i]) mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
    end
endmodule

// File: tb/tb_ysyx_24110015_axi_sram.sv
// Self-checking bench for the AXI-lite SRAM responder: directed scenarios plus a
// randomized read/write mix scored against an associative-array memory model.
module tb_ysyx_24110015_axi_sram;
    localparam logic [31:0] BASE   = 32'h8000_0000;
    localparam int          WORDS  = 4096;
    localparam int          RD_LAT = 1;
    localparam int          WR_LAT = 1;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    logic [31:0] mdl [int];

    axi_lite_if #(.ADDR_W(32)) axi ();

    ysyx_24110015_axi_sram #(
        .ADDR_W(32), .DATA_W(32), .MEM_BASE(BASE), .MEM_WORDS(WORDS),
        .RD_LAT(RD_LAT), .WR_LAT(WR_LAT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .axi(axi)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic bit in_rng(input logic [31:0] a);
        longint unsigned ua;
        ua = {32'd0, a};
        return (ua >= {32'd0, BASE}) && (ua < {32'd0, BASE} + 64'(4 * WORDS));
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'((a - BASE) >> 2);
    endfunction

    function automatic void model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] w;
        if (!in_rng(a)) return;
        w = mdl.exists(widx(a)) ? mdl[widx(a)] : 32'd0;
        for (int i = 0; i < 4; i++) if (s[i]) w[8*i +: 8] = d[8*i +: 8];
        mdl[widx(a)] = w;
    endfunction

    // Bus helpers start and end just after a rising edge; lat is -1 on timeout.
    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            output logic [1:0] resp, output int lat);
        bit aw_ok = 0, w_ok = 0;
        int n = 0, cap = 0;
        lat = -1; resp = 2'b01;
        axi.awaddr = a; axi.awvalid = 1'b1;
        axi.wdata = d; axi.wstrb = s; axi.wvalid = 1'b1;
        while (!(aw_ok && w_ok) && n < 40) begin
            @(negedge clk);
            if (axi.awvalid && axi.awready) aw_ok = 1;
            if (axi.wvalid && axi.wready) w_ok = 1;
            cap = cyc;
            @(posedge clk); #1;
            if (aw_ok) axi.awvalid = 1'b0;
            if (w_ok) axi.wvalid = 1'b0;
            n++;
        end
        axi.awvalid = 1'b0; axi.wvalid = 1'b0;
        if (aw_ok && w_ok) begin
            n = 0;
            @(negedge clk);
            while (!axi.bvalid && n < 40) begin @(negedge clk); n++; end
            if (axi.bvalid) begin lat = cyc - cap; resp = axi.bresp; end
            @(posedge clk); #1;
        end
    endtask

    task automatic do_read(input logic [31:0] a, output logic [31:0] data,
                           output logic [1:0] resp, output int lat);
        bit ok = 0;
        int n = 0, t = 0;
        lat = -1; resp = 2'b01; data = 32'hxxxx_xxxx;
        axi.araddr = a; axi.arvalid = 1'b1;
        while (!ok && n < 40) begin
            @(negedge clk);
            if (axi.arready) ok = 1;
            t = cyc;
            @(posedge clk); #1;
            n++;
        end
        axi.arvalid = 1'b0;
        if (ok) begin
            n = 0;
            @(negedge clk);
            while (!axi.rvalid && n < 40) begin @(negedge clk); n++; end
            if (axi.rvalid) begin lat = cyc - t; data = axi.rdata; resp = axi.rresp; end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        axi.arvalid = 0; axi.awvalid = 0; axi.wvalid = 0;
        axi.araddr = 0; axi.awaddr = 0; axi.wdata = 0; axi.wstrb = 0;
        axi.rready = 1'b1; axi.bready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({axi.arready, axi.awready, axi.wready} !== 3'b000) begin
            errors++; $display("[TB] FAIL reset_readies: got %b required 000", {axi.arready, axi.awready, axi.wready});
        end
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({axi.arready, axi.awready, axi.wready, axi.rvalid, axi.bvalid} !== 5'b11100) begin
            errors++; $display("[TB] FAIL reset_handshake: got %b required 11100",
                               {axi.arready, axi.awready, axi.wready, axi.rvalid, axi.bvalid});
        end
        checks++;
        if ({axi.rdata, axi.rresp, axi.bresp} !== 36'd0) begin
            errors++; $display("[TB] FAIL reset_data: got %h/%b/%b required 0/00/00", axi.rdata, axi.rresp, axi.bresp);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_basic;
        logic [31:0] d; logic [1:0] r; int lat;
        do_write(32'h8000_0010, 32'hDEAD_BEEF, 4'hF, r, lat);
        checks++;
        if (r !== 2'b00 || lat !== 1 + WR_LAT) begin
            errors++; $display("[TB] FAIL basic_write: got resp %b lat %0d required 00 lat %0d", r, lat, 1 + WR_LAT);
        end
        do_read(32'h8000_0010, d, r, lat);
        checks++;
        if (d !== 32'hDEAD_BEEF || r !== 2'b00) begin
            errors++; $display("[TB] FAIL basic_read: got %h/%b required deadbeef/00", d, r);
        end
        checks++;
        if (lat !== 1 + RD_LAT) begin
            errors++; $display("[TB] FAIL basic_read_latency: got %0d required %0d", lat, 1 + RD_LAT);
        end
    endtask

    task automatic test_strobe;
        logic [31:0] d; logic [1:0] r; int lat;
        do_write(32'h8000_0020, 32'h1122_3344, 4'hF, r, lat);
        do_write(32'h8000_0020, 32'hAABB_CCDD, 4'b0101, r, lat);
        checks++;
        if (r !== 2'b00 || lat !== 1 + WR_LAT) begin
            errors++; $display("[TB] FAIL strobe_write: got resp %b lat %0d required 00 lat %0d", r, lat, 1 + WR_LAT);
        end
        do_read(32'h8000_0020, d, r, lat);
        checks++;
        if (d !== 32'h11BB_33DD || r !== 2'b00) begin
            errors++; $display("[TB] FAIL strobe_read: got %h/%b required 11bb33dd/00", d, r);
        end
    endtask

    task automatic test_split_write;
        logic [31:0] d; logic [1:0] r; int lat;
        axi.awaddr = 32'h8000_0004; axi.awvalid = 1'b1;
        @(negedge clk);
        checks++;
        if (axi.awready !== 1'b1) begin
            errors++; $display("[TB] FAIL split_aw_accept: got awready %b required 1", axi.awready);
        end
        @(posedge clk); #1; axi.awvalid = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            if (k == 3) begin axi.wdata = 32'h5; axi.wstrb = 4'hF; axi.wvalid = 1'b1; end
            @(negedge clk);
            checks++;
            if ({axi.awready, axi.wready, axi.bvalid} !== 3'b010) begin
                errors++; $display("[TB] FAIL split_collect_c%0d: got aw/w/b %b required 010", k,
                                   {axi.awready, axi.wready, axi.bvalid});
            end
            @(posedge clk); #1;
            if (k == 3) axi.wvalid = 1'b0;
        end
        @(negedge clk);
        checks++;
        if (axi.bvalid !== 1'b0) begin
            errors++; $display("[TB] FAIL split_bvalid_c4: got %b required 0", axi.bvalid);
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (axi.bvalid !== 1'b1 || axi.bresp !== 2'b00) begin
            errors++; $display("[TB] FAIL split_bvalid_c5: got %b/%b required 1/00", axi.bvalid, axi.bresp);
        end
        @(posedge clk); #1;
        do_read(32'h8000_0004, d, r, lat);
        checks++;
        if (d !== 32'h5 || r !== 2'b00) begin
            errors++; $display("[TB] FAIL split_readback: got %h/%b required 00000005/00", d, r);
        end
    endtask

    task automatic test_decerr;
        logic [31:0] d; logic [1:0] r; int lat;
        do_write(32'h8000_0000, 32'h0BAD_F00D, 4'hF, r, lat);
        do_read(32'h7FFF_FFFC, d, r, lat);
        checks++;
        if (d !== 32'd0 || r !== 2'b11 || lat !== 1 + RD_LAT) begin
            errors++; $display("[TB] FAIL decerr_read_below: got %h/%b lat %0d required 0/11 lat %0d", d, r, lat, 1 + RD_LAT);
        end
        do_write(32'h8000_4000, 32'hFFFF_FFFF, 4'hF, r, lat);
        checks++;
        if (r !== 2'b11) begin
            errors++; $display("[TB] FAIL decerr_write: got bresp %b required 11", r);
        end
        do_read(32'h8000_4000, d, r, lat);
        checks++;
        if (d !== 32'd0 || r !== 2'b11) begin
            errors++; $display("[TB] FAIL decerr_read_above: got %h/%b required 0/11", d, r);
        end
        do_read(32'h8000_0000, d, r, lat);
        checks++;
        if (d !== 32'h0BAD_F00D || r !== 2'b00) begin
            errors++; $display("[TB] FAIL decerr_no_alias: got %h/%b required 0badf00d/00", d, r);
        end
    endtask

    task automatic test_backpressure;
        logic [1:0] r; int lat; int n = 0;
        do_write(32'h8000_0030, 32'hCAFE_F00D, 4'hF, r, lat);
        axi.araddr = 32'h8000_0030; axi.arvalid = 1'b1; axi.rready = 1'b0;
        @(negedge clk);
        @(posedge clk); #1; axi.arvalid = 1'b0;
        @(negedge clk);
        while (!axi.rvalid && n < 40) begin @(negedge clk); n++; end
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (axi.rvalid !== 1'b1 || axi.rdata !== 32'hCAFE_F00D || axi.rresp !== 2'b00 || axi.arready !== 1'b0) begin
                errors++; $display("[TB] FAIL backpressure_hold_%0d: got v%b d%h r%b ar%b required v1 dcafef00d r00 ar0",
                                   k, axi.rvalid, axi.rdata, axi.rresp, axi.arready);
            end
            @(posedge clk); #1;
            if (k == 4) axi.rready = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (axi.rvalid !== 1'b1 || axi.rdata !== 32'hCAFE_F00D) begin
            errors++; $display("[TB] FAIL backpressure_release: got v%b d%h required v1 dcafef00d", axi.rvalid, axi.rdata);
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (axi.rvalid !== 1'b0 || axi.arready !== 1'b1) begin
            errors++; $display("[TB] FAIL backpressure_idle: got rvalid %b arready %b required 0 1", axi.rvalid, axi.arready);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_conflict;
        logic [31:0] d; logic [1:0] r; int lat; int n = 0; bit early = 0;
        do_write(32'h8000_0040, 32'h0102_0304, 4'hF, r, lat);
        axi.araddr = 32'h8000_0040; axi.arvalid = 1'b1;
        axi.awaddr = 32'h8000_0040; axi.awvalid = 1'b1;
        axi.wdata = 32'h0A0B_0C0D; axi.wstrb = 4'hF; axi.wvalid = 1'b1;
        @(negedge clk);
        checks++;
        if ({axi.arready, axi.awready, axi.wready} !== 3'b100) begin
            errors++; $display("[TB] FAIL conflict_priority: got ar/aw/w %b required 100", {axi.arready, axi.awready, axi.wready});
        end
        @(posedge clk); #1; axi.arvalid = 1'b0;
        @(negedge clk);
        while (!axi.rvalid && n < 40) begin
            if (axi.awready || axi.wready) early = 1;
            @(negedge clk); n++;
        end
        if (axi.awready || axi.wready) early = 1;
        checks++;
        if (axi.rvalid !== 1'b1 || axi.rdata !== 32'h0102_0304 || early) begin
            errors++; $display("[TB] FAIL conflict_read_first: got v%b d%h early_w %0d required v1 d01020304 early_w 0",
                               axi.rvalid, axi.rdata, early);
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if ({axi.awready, axi.wready} !== 2'b11) begin
            errors++; $display("[TB] FAIL conflict_write_after: got aw/w %b required 11", {axi.awready, axi.wready});
        end
        @(posedge clk); #1; axi.awvalid = 1'b0; axi.wvalid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!axi.bvalid && n < 40) begin @(negedge clk); n++; end
        checks++;
        if (axi.bvalid !== 1'b1 || axi.bresp !== 2'b00) begin
            errors++; $display("[TB] FAIL conflict_bresp: got %b/%b required 1/00", axi.bvalid, axi.bresp);
        end
        @(posedge clk); #1;
        do_read(32'h8000_0040, d, r, lat);
        checks++;
        if (d !== 32'h0A0B_0C0D) begin
            errors++; $display("[TB] FAIL conflict_readback: got %h required 0a0b0c0d", d);
        end
    endtask

    task automatic test_reset_abort;
        logic [31:0] d; logic [1:0] r; int lat;
        do_write(32'h8000_0050, 32'h55AA_55AA, 4'hF, r, lat);
        axi.araddr = 32'h8000_0050; axi.arvalid = 1'b1;
        @(negedge clk);
        @(posedge clk); #1; axi.arvalid = 1'b0; rst = 1'b1;
        @(negedge clk);
        checks++;
        if (axi.arready !== 1'b0) begin
            errors++; $display("[TB] FAIL abort_rd_forced: got arready %b required 0", axi.arready);
        end
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        checks++;
        if (axi.rvalid !== 1'b0 || axi.arready !== 1'b1) begin
            errors++; $display("[TB] FAIL abort_rd: got rvalid %b arready %b required 0 1", axi.rvalid, axi.arready);
        end
        @(posedge clk); #1;
        axi.awaddr = 32'h8000_0050; axi.awvalid = 1'b1;
        axi.wdata = 32'h1234_5678; axi.wstrb = 4'hF; axi.wvalid = 1'b1;
        @(negedge clk);
        @(posedge clk); #1; axi.awvalid = 1'b0; axi.wvalid = 1'b0; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        checks++;
        if (axi.bvalid !== 1'b0 || axi.bresp !== 2'b00) begin
            errors++; $display("[TB] FAIL abort_wr: got bvalid %b bresp %b required 0 00", axi.bvalid, axi.bresp);
        end
        @(posedge clk); #1;
        do_read(32'h8000_0050, d, r, lat);
        checks++;
        if (d !== 32'h55AA_55AA) begin
            errors++; $display("[TB] FAIL abort_no_commit: got %h required 55aa55aa", d);
        end
    endtask

    function automatic logic [31:0] pick_addr();
        int sel;
        sel = $urandom_range(0, 9);
        if (sel < 8) return BASE + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
        if (sel == 8) return BASE + 32'(4 * (WORDS - 1)) + 32'($urandom_range(0, 3));
        case ($urandom_range(0, 3))
            0: return BASE - 32'd4;
            1: return BASE + 32'(4 * WORDS);
            2: return 32'hFFFF_FFFC;
            default: return 32'($urandom_range(0, 32'h7FFF_FFFF));
        endcase
    endfunction

    task automatic test_random;
        logic [31:0] a, d, wd, exp_d; logic [3:0] s; logic [1:0] r, exp_r; int lat;
        for (int i = 0; i < 17; i++) begin
            a = (i == 16) ? BASE + 32'(4 * (WORDS - 1)) : BASE + 32'(4 * i);
            wd = $urandom;
            do_write(a, wd, 4'hF, r, lat);
            model_write(a, wd, 4'hF);
        end
        for (int i = 0; i < 60; i++) begin
            a = pick_addr();
            exp_r = in_rng(a) ? 2'b00 : 2'b11;
            if ($urandom_range(0, 1) == 0) begin
                wd = $urandom;
                s = 4'($urandom_range(0, 15));
                do_write(a, wd, s, r, lat);
                model_write(a, wd, s);
                checks++;
                if (r !== exp_r || lat !== 1 + WR_LAT) begin
                    errors++; $display("[TB] FAIL rand_write_%0d @%h: got resp %b lat %0d required %b lat %0d",
                                       i, a, r, lat, exp_r, 1 + WR_LAT);
                end
            end else begin
                exp_d = in_rng(a) ? mdl[widx(a)] : 32'd0;
                do_read(a, d, r, lat);
                checks++;
                if (d !== exp_d || r !== exp_r || lat !== 1 + RD_LAT) begin
                    errors++; $display("[TB] FAIL rand_read_%0d @%h: got %h/%b lat %0d required %h/%b lat %0d",
                                       i, a, d, r, lat, exp_d, exp_r, 1 + RD_LAT);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_strobe();
        test_split_write();
        test_decerr();
        test_backpressure();
        test_conflict();
        test_reset_abort();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
